// File: rtl/inst_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_queue_if                                                              |
// | Fetch-side push bundle and dispatch-side delivery bundle of inst_queue.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface inst_queue_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_pred_jump;
    logic [31:0] if_pred_pc;
    logic        is_full;

    logic        dp_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_pred_jump;
    logic [31:0] out_pred_pc;

    // master: the fetcher/dispatch environment; slave: the queue itself
    modport master (
        output if_valid, if_inst, if_pc, if_pred_jump, if_pred_pc, dp_ready,
        input  is_full, out_valid, out_inst, out_pc, out_pred_jump, out_pred_pc
    );

    modport slave (
        input  if_valid, if_inst, if_pc, if_pred_jump, if_pred_pc, dp_ready,
        output is_full, out_valid, out_inst, out_pc, out_pred_jump, out_pred_pc
    );
endinterface
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_queue                                                                 |
// | Circular instruction FIFO between fetch and decode/dispatch, with flush    |
// | and conservative is_full. Optional empty-queue bypass: IQ_BYPASS_EN.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   rdy,
    input  wire logic   flush,
    inst_queue_if.slave q
);

    localparam int              c_ENTRY_W  = 97;
    localparam int              c_FULL_INT = DEPTH - 2;
    localparam logic [PTR_W:0]  c_DEPTH    = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]  c_FULL_THR = c_FULL_INT[PTR_W:0];

    generate
        if (((1 << PTR_W) != DEPTH) || (DEPTH < 4)) begin : g_bad_params
            $error("inst_queue: DEPTH must be a power of two >= 4 and equal 2**PTR_W");
        end
    endgenerate

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W:0]       r_count;
    logic                 r_out_valid;
    logic [c_ENTRY_W-1:0] r_out;

    logic [c_ENTRY_W-1:0] w_entry;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;

    assign w_entry = {q.if_inst, q.if_pc, q.if_pred_jump, q.if_pred_pc};

`ifdef IQ_BYPASS_EN
    // Empty queue with a consumer waiting: hand the fetched word straight out.
    assign w_bypass = (r_count == '0) && q.if_valid && q.dp_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = q.if_valid && (r_count < c_DEPTH) && !w_bypass;
    assign w_pop  = q.dp_ready && (r_count != '0);

    // Two slots of headroom cover the fetcher's registered push already in flight.
    assign q.is_full = (r_count >= c_FULL_THR);

    assign q.out_valid = r_out_valid;
    assign {q.out_inst, q.out_pc, q.out_pred_jump, q.out_pred_pc} = r_out;

    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush && w_push) begin
            r_mem[r_tail] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (!rdy) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_bypass) begin
                r_out       <= w_entry;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                // Reads the old head; a same-cycle write lands at the tail.
                r_out       <= r_mem[r_head];
                r_out_valid <= 1'b1;
                r_head      <= r_head + 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end

            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_queue                                                              |
// | Self-checking bench for inst_queue against a queue-based reference model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
`ifdef IQ_BYPASS_EN
    localparam int c_LAT = 1;
`else
    localparam int c_LAT = 2;
`endif

    typedef logic [96:0] entry_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;

    inst_queue_if ifc ();

    inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .q     (ifc)
    );

    always #5 clk = ~clk;

    entry_t out_e;
    assign out_e = {ifc.out_inst, ifc.out_pc, ifc.out_pred_jump, ifc.out_pred_pc};

    // Reference model: an ordered list of stored instructions plus the output register.
    entry_t      mq [$];
    entry_t      m_out;
    logic        m_valid;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] got_pc [$];

    task automatic model_edge();
        entry_t e;
        int     sz;
        sz = mq.size();
        e  = {ifc.if_inst, ifc.if_pc, ifc.if_pred_jump, ifc.if_pred_pc};
        if (rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_out   = '0;
        end else if (!rdy) begin
            m_valid = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
`ifdef IQ_BYPASS_EN
            if (sz == 0 && ifc.if_valid && ifc.dp_ready) begin
                m_out   = e;
                m_valid = 1'b1;
            end else
`endif
            begin
                if (ifc.dp_ready && sz > 0) begin
                    m_out   = mq.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                if (ifc.if_valid && sz < DEPTH) mq.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        ifc.if_valid     = v;
        ifc.if_pc        = pc;
        ifc.if_inst      = $urandom;
        ifc.if_pred_jump = 1'($urandom);
        ifc.if_pred_pc   = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; flush = 1'b1; ifc.dp_ready = 1'b1;
        drive(1'b1, 32'h44);
        cycle();
        cycle();
        n_total++;
        if (ifc.out_valid !== 1'b0 || out_e !== '0 || ifc.is_full !== 1'b0 || dut.r_count !== 5'd0)
            $display("FAIL reset_state: got v=%b e=%h full=%b cnt=%0d, want all zero", ifc.out_valid, out_e, ifc.is_full, dut.r_count);
        else n_pass++;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; ifc.dp_ready = 1'b0;
        drive(1'b0, 32'h0);
        cycle();
        n_total++;
        if (ifc.out_valid !== m_valid || out_e !== m_out || ifc.is_full !== (mq.size() >= DEPTH-2) || dut.r_count !== 5'(mq.size()))
            $display("FAIL reset_idle: got v=%b cnt=%0d, want v=%b cnt=%0d", ifc.out_valid, dut.r_count, m_valid, mq.size());
        else n_pass++;
    endtask

    task automatic test_basic();
        int first = -1;
        got_pc.delete();
        ifc.dp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i < 3, 32'(4 * i));
            cycle();
            n_total++;
            if (ifc.out_valid !== m_valid || out_e !== m_out || ifc.is_full !== (mq.size() >= DEPTH-2) || dut.r_count !== 5'(mq.size()))
                $display("FAIL basic_cycle%0d: got v=%b e=%h cnt=%0d, want v=%b e=%h cnt=%0d", i, ifc.out_valid, out_e, dut.r_count, m_valid, m_out, mq.size());
            else n_pass++;
            if (ifc.out_valid === 1'b1) begin
                got_pc.push_back(ifc.out_pc);
                if (first < 0) first = i;
            end
        end
        drive(1'b0, 32'h0);
        n_total++;
        if (first != c_LAT - 1)
            $display("FAIL basic_latency: got first pulse after %0d cycles, want %0d", first + 1, c_LAT);
        else n_pass++;
        n_total++;
        if (got_pc.size() != 3 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8)
            $display("FAIL basic_order: got %0d outputs, want pc 0x0/0x4/0x8", got_pc.size());
        else n_pass++;
    endtask

    task automatic test_full();
        int err = 0;
        ifc.dp_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i));
            cycle();
            n_total++;
            if (ifc.out_valid !== m_valid || out_e !== m_out || ifc.is_full !== (mq.size() >= DEPTH-2) || dut.r_count !== 5'(mq.size()))
                $display("FAIL full_fill%0d: got full=%b cnt=%0d, want full=%b cnt=%0d", i, ifc.is_full, dut.r_count, mq.size() >= DEPTH-2, mq.size());
            else n_pass++;
            if (i == 12 || i == 13) begin
                n_total++;
                if (ifc.is_full !== (i == 13))
                    $display("FAIL full_threshold%0d: got is_full=%b, want %b", i + 1, ifc.is_full, i == 13);
                else n_pass++;
            end
        end
        n_total++;
        if (dut.r_count !== 5'd16)
            $display("FAIL full_drop: got count=%0d, want 16", dut.r_count);
        else n_pass++;
        drive(1'b0, 32'h0);
        ifc.dp_ready = 1'b1;
        got_pc.delete();
        for (int i = 0; i < 24; i++) begin
            cycle();
            n_total++;
            if (ifc.out_valid !== m_valid || out_e !== m_out || ifc.is_full !== (mq.size() >= DEPTH-2) || dut.r_count !== 5'(mq.size()))
                $display("FAIL full_drain%0d: got v=%b e=%h, want v=%b e=%h", i, ifc.out_valid, out_e, m_valid, m_out);
            else n_pass++;
            if (ifc.out_valid === 1'b1) got_pc.push_back(ifc.out_pc);
        end
        foreach (got_pc[k]) if (got_pc[k] !== 32'h200 + 32'(4 * k)) err++;
        n_total++;
        if (got_pc.size() != 16 || err != 0)
            $display("FAIL full_drain_order: got %0d outputs (%0d out of order), want 16", got_pc.size(), err);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int err    = 0;
        int cyc    = 0;
        got_pc.delete();
        while ((pushed < 40 || got_pc.size() < 40) && cyc < 400) begin
            ifc.dp_ready = cyc[0];
            if (pushed < 40 && ifc.is_full === 1'b0 && $urandom_range(3) != 0) begin
                drive(1'b1, 32'(4 * pushed));
                pushed++;
            end else begin
                drive(1'b0, 32'h0);
            end
            cycle();
            cyc++;
            n_total++;
            if (ifc.out_valid !== m_valid || out_e !== m_out || ifc.is_full !== (mq.size() >= DEPTH-2) || dut.r_count !== 5'(mq.size()))
                $display("FAIL wrap_cycle%0d: got v=%b e=%h cnt=%0d, want v=%b e=%h cnt=%0d", cyc, ifc.out_valid, out_e, dut.r_count, m_valid, m_out, mq.size());
            else n_pass++;
            if (ifc.out_valid === 1'b1) got_pc.push_back(ifc.out_pc);
        end
        drive(1'b0, 32'h0);
        foreach (got_pc[k]) if (got_pc[k] !== 32'(4 * k)) err++;
        n_total++;
        if (got_pc.size() != 40 || err != 0)
            $display("FAIL wrap_order: got %0d outputs (%0d out of order) in %0d cycles, want 40 in order", got_pc.size(), err, cyc);
        else n_pass++;
    endtask

    task automatic test_flush();
        int first = -1;
        ifc.dp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i));
            cycle();
        end
        ifc.dp_ready = 1'b1;
        drive(1'b1, 32'h514);
        cycle();
        n_total++;
        if (dut.r_count !== 5'd5 || ifc.out_valid !== 1'b1 || out_e !== m_out)
            $display("FAIL flush_setup: got cnt=%0d v=%b, want cnt=5 v=1", dut.r_count, ifc.out_valid);
        else n_pass++;
        flush = 1'b1;
        drive(1'b1, 32'h518);
        cycle();
        flush = 1'b0;
        n_total++;
        if (dut.r_count !== 5'd0 || ifc.out_valid !== 1'b0 || ifc.is_full !== 1'b0 || mq.size() != 0)
            $display("FAIL flush_clear: got cnt=%0d v=%b full=%b, want 0/0/0", dut.r_count, ifc.out_valid, ifc.is_full);
        else n_pass++;
        drive(1'b1, 32'h100);
        for (int i = 0; i < 5; i++) begin
            cycle();
            drive(1'b0, 32'h0);
            n_total++;
            if (ifc.out_valid !== m_valid || out_e !== m_out || dut.r_count !== 5'(mq.size()))
                $display("FAIL flush_after%0d: got v=%b e=%h, want v=%b e=%h", i, ifc.out_valid, out_e, m_valid, m_out);
            else n_pass++;
            if (ifc.out_valid === 1'b1 && first < 0) first = int'(ifc.out_pc);
        end
        n_total++;
        if (first != 32'h100)
            $display("FAIL flush_next: got first pc=%h, want 00000100", first);
        else n_pass++;
    endtask

    task automatic test_stall();
        int outs = 0;
        ifc.dp_ready = 1'b0;
        rdy = 1'b0;
        drive(1'b1, 32'h300);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_total++;
            if (ifc.out_valid !== 1'b0 || dut.r_count !== 5'd0 || out_e !== m_out)
                $display("FAIL stall_cycle%0d: got v=%b cnt=%0d, want v=0 cnt=0", i, ifc.out_valid, dut.r_count);
            else n_pass++;
        end
        rdy = 1'b1;
        cycle();
        drive(1'b0, 32'h0);
        n_total++;
        if (dut.r_count !== 5'd1 || mq.size() != 1)
            $display("FAIL stall_once: got cnt=%0d, want 1", dut.r_count);
        else n_pass++;
        ifc.dp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (ifc.out_valid === 1'b1) begin
                outs++;
                n_total++;
                if (ifc.out_pc !== 32'h300 || out_e !== m_out)
                    $display("FAIL stall_out: got pc=%h, want 00000300", ifc.out_pc);
                else n_pass++;
            end
        end
        n_total++;
        if (outs != 1)
            $display("FAIL stall_count: got %0d outputs, want 1", outs);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int err = 0;
        ifc.dp_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i));
            cycle();
        end
        got_pc.delete();
        ifc.dp_ready = 1'b1;
        for (int i = 14; i < 24; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i));
            cycle();
            n_total++;
            if (ifc.is_full !== 1'b1 || dut.r_count !== 5'd14 || ifc.out_valid !== 1'b1 || out_e !== m_out)
                $display("FAIL b2b_cycle%0d: got full=%b cnt=%0d v=%b, want full=1 cnt=14 v=1", i, ifc.is_full, dut.r_count, ifc.out_valid);
            else n_pass++;
            if (ifc.out_valid === 1'b1) got_pc.push_back(ifc.out_pc);
        end
        drive(1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (ifc.out_valid === 1'b1) got_pc.push_back(ifc.out_pc);
        end
        foreach (got_pc[k]) if (got_pc[k] !== 32'h400 + 32'(4 * k)) err++;
        n_total++;
        if (got_pc.size() != 24 || err != 0)
            $display("FAIL b2b_order: got %0d outputs (%0d out of order), want 24", got_pc.size(), err);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst          = ($urandom_range(99) == 0);
            rdy          = ($urandom_range(9) != 0);
            flush        = ($urandom_range(31) == 0);
            ifc.dp_ready = 1'($urandom);
            drive($urandom_range(9) < 6, $urandom);
            cycle();
            n_total++;
            if (ifc.out_valid !== m_valid || out_e !== m_out || ifc.is_full !== (mq.size() >= DEPTH-2) || dut.r_count !== 5'(mq.size()))
                $display("FAIL random_cycle%0d: got v=%b e=%h full=%b cnt=%0d, want v=%b e=%h full=%b cnt=%0d", i, ifc.out_valid, out_e, ifc.is_full, dut.r_count, m_valid, m_out, mq.size() >= DEPTH-2, mq.size());
            else n_pass++;
        end
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ifc.dp_ready = 1'b0;
        drive(1'b0, 32'h0);
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_flush();
        test_stall();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO between the instruction fetcher and the decode/dispatch stage.
- Buffers fetched instructions together with their PC and branch-prediction info.
- Gives the fetcher conservative back-pressure via is_full.
- Discards all contents on a pipeline flush (misprediction rollback).

Parameters:
- DEPTH, 16: number of entries; must be a power of two, ≥4.
- PTR_W, 4: log2(DEPTH); width of the head and tail pointers.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- rdy  input  1  global enable; low freezes the block
- flush  input  1  rollback; discard all entries
- if_valid  input  1  push strobe from the fetcher (registered on the fetcher side)
- if_inst  input  32  instruction word
- if_pc  input  32  instruction PC
- if_pred_jump  input  1  predicted taken
- if_pred_pc  input  32  predicted next PC
- is_full  output  1  back-pressure to the fetcher
- dp_ready  input  1  downstream can accept an instruction this cycle
- out_valid  output  1  one-cycle pulse per delivered instruction
- out_inst  output  32  delivered instruction
- out_pc  output  32  delivered PC
- out_pred_jump  output  1  delivered prediction
- out_pred_pc  output  32  delivered predicted PC

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - head, tail, count, out_valid, out_inst, out_pc, out_pred_jump and out_pred_pc all become 0.
  - Reset overrides rdy and flush.
- Storage: DEPTH entries of {inst[31:0], pc[31:0], pred_jump, pred_pc[31:0]}.
  - head and tail are PTR_W bits and wrap naturally modulo DEPTH.
  - count is PTR_W+1 bits, range 0..DEPTH.
- rdy low: no state change and push ignored; out_valid is cleared to 0 at the edge.
  - A fetcher valid held across a rdy-low stall is therefore accepted exactly once, on the first rdy-high cycle.
- Priority when rdy is high: flush > pop/push.
- Flush: at the edge, head, tail and count are set to 0 and out_valid to 0.
  - A push or pop in the same cycle is discarded.
- Push: if_valid && count<DEPTH.
  - Writes the entry at tail; tail+1.
  - A push when count==DEPTH is dropped with no state change. The fetcher never causes this while it honours is_full.
- Pop: dp_ready && count>0.
  - Entry at head is registered onto the out_* ports; out_valid=1 next cycle; head+1.
  - Otherwise out_valid=0 and out_* hold their previous values.
- Simultaneous push and pop: count unchanged.
  - Pop reads the old head entry, never the entry being written this cycle.
- is_full is combinational, high when count ≥ DEPTH-2.
  - This reserves one slot for the fetcher's in-flight registered push and one for the push it issues on the same edge.
- Latency: push at cycle t → earliest out_valid at t+2.
- Throughput: one push and one pop per cycle.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined: when count==0, if_valid, dp_ready, !flush and rdy, the incoming instruction goes directly to the out_* registers.
  - out_valid=1 at t+1 and the entry is not stored.
  - Latency is 1 cycle when the queue is empty.
- Undefined: every instruction passes through storage; latency is always ≥2.
- Architectural order is identical in both builds.

Test Plan:
1. Reset, then 3 pushes (pc 0x0, 0x4, 0x8) with dp_ready=1 → out_valid pulses in order with pc 0x0/0x4/0x8; first pulse at push-cycle+2 (bypass build: +1).
2. dp_ready=0 with 14 pushes → is_full rises when count reaches 14; a forced extra 3 pushes leave count=16 and the 17th is dropped; then drain → exactly 16 outputs in order.
3. Wrap-around: 40 pushes interleaved with dp_ready toggling 1/0 → all 40 pc values (0x0..0x9C) delivered once, in order.
4. count=5 with flush, if_valid and dp_ready all high in the same cycle → next cycle count=0, out_valid=0, is_full=0; the next push (pc 0x100) is the next delivered.
5. if_valid held high with rdy=0 for 4 cycles, then rdy=1 → exactly one entry is pushed; out_valid stays 0 during the stall.
6. count=14 with simultaneous push and pop each cycle for 10 cycles → count stays 14, is_full stays high, no drops.
